// File: rtl/sng_bitstream_pkg.sv
// Package for the SNG bitstream stage: wraps the shared state encoding in a
// typed enum.
package sng_bitstream_pkg;

    `include "sng_defs.vh"

    typedef enum logic [1:0] {
        IDLE = SNG_ST_IDLE,
        SEED = SNG_ST_SEED,
        RUN  = SNG_ST_RUN,
        DONE = SNG_ST_DONE
    } state_e;

endpackage

// File: rtl/register.sv
// Common enabled register with asynchronous active-low clear to zero.
module register #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input before any flop updates in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sng_compare.sv
// Combinational comparator: top PW bits of the RNG word against a PW+1 bit
// probability, saturated at 2^PW.
module sng_compare #(
    parameter int PW = 16
) (
    input  logic [31:0] rnd,
    input  logic [PW:0] prob,
    output logic        hit
);

    logic [PW:0] prob_sat;

    // Anything at or above 2^PW is treated as exactly 2^PW (always a hit).
    assign prob_sat = prob[PW] ? {1'b1, {PW{1'b0}}} : prob;
    assign hit      = ({1'b0, rnd[31 -: PW]} < prob_sat);

    if (PW < 32) begin : g_unused
        logic unused_rnd_low;
        assign unused_rnd_low = ^rnd[31-PW:0];
    end

endmodule

// File: rtl/sng_defs.vh
// Shared definitions for the stochastic number generator: state encoding and
// default widths.
`ifndef SNG_DEFS_VH
`define SNG_DEFS_VH

localparam logic [1:0] SNG_ST_IDLE = 2'd0;
localparam logic [1:0] SNG_ST_SEED = 2'd1;
localparam logic [1:0] SNG_ST_RUN  = 2'd2;
localparam logic [1:0] SNG_ST_DONE = 2'd3;

localparam int SNG_PW_DEFAULT = 16;
localparam int SNG_LW_DEFAULT = 16;

`endif

// File: rtl/sng_bitstream.sv
// SNG stage: turns the xorshift word into a valid/ready Bernoulli bitstream of
// programmable length and probability. Optional ones counter: SNG_ONES_COUNT_EN.
module sng_bitstream
    import sng_bitstream_pkg::*;
#(
    parameter int PW = SNG_PW_DEFAULT,
    parameter int LW = SNG_LW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   rnd,
    output logic [31:0]   rng_seed,
    output logic          rng_re_seed,
    input  logic          start,
    input  logic          start_reseed,
    input  logic [31:0]   seed,
    input  logic [PW:0]   prob,
    input  logic [LW-1:0] len,
    output logic          out_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
`ifdef SNG_ONES_COUNT_EN
    ,
    output logic [LW-1:0] ones_cnt
`endif
);

    logic [1:0]    state_q;
    state_e        state;
    state_e        state_d;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic [LW-1:0] len_q;
    logic [PW:0]   prob_q;
    logic [31:0]   seed_q;
    logic          bit_q;
    logic          valid_q;
    logic          hit;
    logic          idle_start;
    logic          accept;
    logic          at_len;
    logic          load;

    assign state      = state_e'(state_q);
    assign idle_start = (state == IDLE) && start;
    assign accept     = valid_q && out_ready;
    assign at_len     = (cnt_q == len_q);
    assign load       = (state == RUN) && !at_len && (!valid_q || out_ready);
    assign cnt_d      = idle_start ? '0 : cnt_q + LW'(1);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)        state_d = DONE;
                    else if (start_reseed) state_d = SEED;
                    else                   state_d = RUN;
                end
            end
            SEED:    state_d = RUN;
            RUN:     if (accept && at_len) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    register #(.W(2)) u_state (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d), .q(state_q)
    );

    register #(.W(LW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .en(idle_start || load), .d(cnt_d), .q(cnt_q)
    );

    register #(.W(LW)) u_len (
        .clk(clk), .rst_n(rst_n), .en(idle_start), .d(len), .q(len_q)
    );

    register #(.W(PW+1)) u_prob (
        .clk(clk), .rst_n(rst_n), .en(idle_start), .d(prob), .q(prob_q)
    );

    register #(.W(32)) u_seed (
        .clk(clk), .rst_n(rst_n), .en(idle_start), .d(seed), .q(seed_q)
    );

    sng_compare #(.PW(PW)) u_compare (
        .rnd(rnd), .prob(prob_q), .hit(hit)
    );

    // One-entry output buffer: words arriving while it is stalled are dropped.
    register #(.W(1)) u_bit (
        .clk(clk), .rst_n(rst_n), .en(load), .d(hit), .q(bit_q)
    );

    register #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .en(load || accept), .d(load), .q(valid_q)
    );

`ifdef SNG_ONES_COUNT_EN
    logic [LW-1:0] ones_q;
    logic [LW-1:0] ones_d;

    assign ones_d = idle_start ? '0 : ones_q + LW'(1);

    register #(.W(LW)) u_ones (
        .clk(clk), .rst_n(rst_n), .en(idle_start || (accept && bit_q)),
        .d(ones_d), .q(ones_q)
    );

    assign ones_cnt = ones_q;
`endif

    assign rng_seed    = seed_q;
    assign rng_re_seed = (state == SEED);
    assign out_bit     = bit_q;
    assign out_valid   = valid_q;
    assign busy        = (state == SEED) || (state == RUN);
    assign done        = (state == DONE);

endmodule

// File: doc/sng_bitstream.md
Name: sng_bitstream

Overview:
- Stochastic number generator (SNG) stage that sits directly downstream of the 32-bit xorshift RNG.
- Converts the per-cycle random word `rnd` into a Bernoulli bitstream of programmable length and probability, with valid/ready output.
- Also drives the RNG's reseed controls, so every stream can start from a known seed for reproducible stochastic-computing experiments.

Parameters:
- PW, 16: probability resolution in bits. The compare uses `rnd[31 -: PW]`.
- LW, 16: stream-length counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- rnd  in  32  current RNG state word; the RNG advances every cycle unconditionally
- rng_seed  out  32  seed driven to the RNG
- rng_re_seed  out  1  reseed strobe to the RNG, active high
- start  in  1  start request, sampled only in IDLE
- start_reseed  in  1  with start: 1 = reseed before streaming, 0 = continue the current RNG sequence
- seed  in  32  seed value, latched on an accepted start
- prob  in  PW+1  probability numerator over 2^PW; 0 gives all zeros, 2^PW gives all ones
- len  in  LW  number of bits to emit
- out_bit  out  1  stream bit
- out_valid  out  1  out_bit is valid
- out_ready  in  1  consumer accepts out_bit
- busy  out  1  high in SEED or RUN
- done  out  1  one-cycle pulse when the stream completes

Behaviour:
- Reset: all outputs are 0. State is IDLE; counter, latched prob/len/seed and the sample register are all cleared. Reset asserted mid-stream aborts immediately; no done pulse.
- States: IDLE, SEED, RUN, DONE. Registered FSM; all outputs are registered or decoded from state/registers only, with no combinational path from any input to any output.
- IDLE: on start=1, latch prob, len and seed, and clear the counter. Then:
  - len==0 goes to DONE;
  - else start_reseed=1 goes to SEED;
  - else it goes to RUN.
- IDLE is the only state that samples start; start is ignored in every other state.
- SEED (exactly 1 cycle): rng_re_seed=1 and rng_seed=latched seed. The RNG loads the seed at the clock edge. Next state is RUN, and the first `rnd` seen in RUN equals seed.
- rng_seed holds the latched seed at all times. rng_re_seed is high only in SEED.
- RUN:
  - Sample register `bit_q` and its valid flag `out_valid` form a 1-entry buffer.
  - Each cycle in which the buffer is empty, or is being drained (out_valid && out_ready), load `bit_q <= (rnd[31 -: PW] < prob)` (zero-extended PW+1-bit compare), set out_valid=1 and increment the counter.
  - When the counter reaches len, stop loading. The cycle the last bit is accepted goes to DONE with out_valid=0.
  - Under backpressure, out_bit and out_valid are held stable. RNG words arriving during stalls are discarded.
  - Bit k (k=0..len-1) comes from the k-th RNG state after stream start only when out_ready is held high throughout.
- Latency with reseed and out_ready=1: start accepted at edge T0, SEED during T0..T1, first load at edge T2, first out_valid high after T2. The final bit is accepted in a later cycle, then done pulses one cycle later.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start in DONE is ignored.
- Probability bounds: prob=0 gives all 0s. prob≥2^PW gives all 1s. Values of prob above 2^PW behave as 2^PW.

Optional Feature:
- Macro: SNG_ONES_COUNT_EN.
- Defined: adds output port `ones_cnt` (LW bits), which counts accepted 1-bits in the current stream. It clears on an accepted start, stays valid from the done pulse until the next start, and is reset to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared header `sng_defs.vh`, with include guard, holds:
  - the state encoding localparams (IDLE=2'd0, SEED=2'd1, RUN=2'd2, DONE=2'd3);
  - the default PW and LW.
- All state, counter and latch flops use the common Register module.
- One sub-module, sng_compare: purely combinational `rnd` slice vs prob comparator with saturation. It is reused by future multi-stream SNGs.

Test Plan:
- Reseed determinism (PW=16, seed=32'h1, prob=5, len=2, out_ready=1): bits are 1 then 1, since the top-16 slices are 0x0000 and 0x0004 (0x42021). Repeat with prob=4: bits are 1 then 0. busy is high from T0+1; exactly one done pulse; exactly one rng_re_seed cycle.
- Bounds: prob=0, len=100 gives 100 zeros; prob=65536 gives 100 ones; prob=65535+2 saturates to all ones. ones_cnt (if enabled) is 0 / 100 / 100.
- len=0 with start: no out_valid, no rng_re_seed, done pulses in the second cycle after start, busy stays 0.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream; out_bit and out_valid stay stable. The total accepted bit count still equals len=16.
- Start ignored: pulse start with different prob/len during RUN and in DONE; the stream is unchanged and no extra done occurs. start_reseed=0 gives no rng_re_seed.
- Reset mid-RUN: assert rst_n=0 asynchronously. All outputs are 0 immediately, no done, and a fresh start afterwards behaves as the first scenario.
